// File: rtl/dma_axi_addr_chan.sv
// dma_axi_addr_chan: AXI AR/AW address issuer for the DMA streamer.
// Queues burst requests, caps outstanding bursts, flags response errors.
module dma_axi_addr_chan #(
  parameter int CHANNEL         = 0,
  parameter int ADDR_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [7:0]            req_alen_i,
  input  logic [2:0]            req_size_i,
  input  logic                  req_mode_i,
  input  logic                  abort_i,
  output logic                  ax_valid_o,
  input  logic                  ax_ready_i,
  output logic [ADDR_WIDTH-1:0] ax_addr_o,
  output logic [7:0]            ax_len_o,
  output logic [2:0]            ax_size_o,
  output logic [1:0]            ax_burst_o,
  input  logic                  cpl_valid_i,
  input  logic [1:0]            cpl_resp_i,
  input  logic                  err_clr_i,
  output logic [1:0]            err_o,
  output logic [7:0]            outstanding_o,
  output logic                  idle_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + 12;
  localparam logic [PW:0] FD_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0] MAX_C = 8'(MAX_OUTSTANDING);

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      MAX_OUTSTANDING < 1 ||
      MAX_OUTSTANDING > 255 ||
      CHANNEL < 0 || CHANNEL > 1) begin : g_param_chk
    $error("dma_axi_addr_chan: bad parameter");
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   fcnt_q;

  logic                  ax_valid_q;
  logic [ADDR_WIDTH-1:0] ax_addr_q;
  logic [7:0]            ax_len_q;
  logic [2:0]            ax_size_q;
  logic [1:0]            ax_burst_q;

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;

  logic full, empty, push, load, reg_free, dec;
  logic [1:0] err_new;
  logic [EW-1:0] head;
  logic unused_resp;

  assign unused_resp = cpl_resp_i[0];

  assign full     = (fcnt_q == FD_C);
  assign empty    = (fcnt_q == '0);
  assign reg_free = !ax_valid_q || ax_ready_i;
  assign push     = req_valid_i && req_ready_o;
  assign load     = reg_free && !empty &&
                    (cnt_q < MAX_C) && !abort_i;
  assign head     = mem_q[rptr_q];

  assign req_ready_o   = !full && !abort_i;
  assign ax_valid_o    = ax_valid_q;
  assign ax_addr_o     = ax_addr_q;
  assign ax_len_o      = ax_len_q;
  assign ax_size_o     = ax_size_q;
  assign ax_burst_o    = ax_burst_q;
  assign err_o         = err_q;
  assign outstanding_o = cnt_q;
  assign idle_o        = empty && (cnt_q == '0);

  // Next outstanding count and sticky errors; a stray completion never underflows.
  always_comb begin
    dec     = cpl_valid_i && (cnt_q != '0);
    cnt_d   = cnt_q + 8'(load) - 8'(dec);
    err_new = {cpl_valid_i && (cnt_q == '0),
               cpl_valid_i && cpl_resp_i[1]};
    err_d   = (err_clr_i ? 2'b00 : err_q) | err_new;
  end

  // Request FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_addr_i, req_alen_i,
                                req_size_i, req_mode_i};
  end

  // FIFO pointers and fill level; abort flushes everything at once.
  always_ff @(posedge clk) begin
    if (!rst || abort_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (load) rptr_q <= rptr_q + 1'b1;
      fcnt_q <= fcnt_q + (PW+1)'(push) - (PW+1)'(load);
    end
  end

  // Output register: holds a beat until accepted, reloads back to back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ax_valid_q <= 1'b0;
      ax_addr_q  <= '0;
      ax_len_q   <= '0;
      ax_size_q  <= '0;
      ax_burst_q <= 2'b01;
    end else if (load) begin
      ax_valid_q <= 1'b1;
      ax_addr_q  <= head[EW-1:12];
      ax_len_q   <= head[11:4];
      ax_size_q  <= head[3:1];
      ax_burst_q <= head[0] ? 2'b00 : 2'b01;
    end else if (ax_ready_i) begin
      ax_valid_q <= 1'b0;
    end
  end

  // Outstanding burst counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_axi_addr_chan.sv
// tb_dma_axi_addr_chan: directed bench with a queue-based reference model.
// Per-cycle compare against the model plus hand-computed literal checks.
module tb_dma_axi_addr_chan;

  localparam int FD   = 4;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_alen;
  logic [2:0]  req_size;
  logic        req_mode;
  logic        abort;
  logic        ax_valid;
  logic        ax_ready;
  logic [31:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic        cpl_valid;
  logic [1:0]  cpl_resp;
  logic        err_clr;
  logic [1:0]  err;
  logic [7:0]  outstanding;
  logic        idle;

  dma_axi_addr_chan #(
    .CHANNEL(0), .ADDR_WIDTH(32),
    .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_alen_i(req_alen),
    .req_size_i(req_size), .req_mode_i(req_mode),
    .abort_i(abort),
    .ax_valid_o(ax_valid), .ax_ready_i(ax_ready),
    .ax_addr_o(ax_addr), .ax_len_o(ax_len),
    .ax_size_o(ax_size), .ax_burst_o(ax_burst),
    .cpl_valid_i(cpl_valid), .cpl_resp_i(cpl_resp),
    .err_clr_i(err_clr), .err_o(err),
    .outstanding_o(outstanding), .idle_o(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    logic        m;
  } req_t;

  req_t        m_q[$];
  req_t        m_slot;
  bit          m_v;
  int          m_cnt;
  logic [1:0]  m_err;
  bit          m_rdy, m_ld, m_e0, m_e1;

  logic [31:0] log_q[$];
  bit          chk_en = 0;
  int          npass = 0;
  int          ntot  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a request queue, one held slot, a counter.
  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_v   = 0;
      m_cnt = 0;
      m_err = 2'b00;
    end else begin
      m_rdy = (m_q.size() < FD) && !abort;
      m_ld  = (!m_v || ax_ready) && (m_q.size() > 0) &&
              (m_cnt < MAXO) && !abort;
      m_e1  = cpl_valid && (m_cnt == 0);
      m_e0  = cpl_valid && cpl_resp[1];
      if (m_ld) begin
        m_slot = m_q.pop_front();
        m_v    = 1;
      end else if (ax_ready) begin
        m_v = 0;
      end
      if (abort) m_q.delete();
      else if (req_valid && m_rdy)
        m_q.push_back('{req_addr, req_alen, req_size, req_mode});
      m_cnt = m_cnt + int'(m_ld) - int'(cpl_valid && !m_e1);
      if (err_clr) m_err = 2'b00;
      m_err = m_err | {m_e1, m_e0};
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_req_ready", req_ready,
          (m_q.size() < FD) && !abort);
      chk("cyc_ax_valid", ax_valid, m_v);
      if (m_v) begin
        chk("cyc_ax_addr", ax_addr, m_slot.a);
        chk("cyc_ax_len", ax_len, m_slot.l);
        chk("cyc_ax_size", ax_size, m_slot.s);
        chk("cyc_ax_burst", ax_burst,
            m_slot.m ? 2'b00 : 2'b01);
      end
      chk("cyc_outstanding", outstanding, m_cnt);
      chk("cyc_err", err, m_err);
      chk("cyc_idle", idle, (m_q.size() == 0) && (m_cnt == 0));
      if (ax_valid && ax_ready) log_q.push_back(ax_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic m);
    req_addr = a;
    req_alen = l;
    req_size = s;
    req_mode = m;
  endtask

  task automatic push_n(input int n, input logic [31:0] base,
                        input int budget);
    int acc = 0;
    for (int c = 0; c < budget && acc < n; c++) begin
      set_req(base + 32'(acc) * 32'h100, 8'd3, 3'd2, 1'b0);
      req_valid = 1'b1;
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("push_accepts", acc, n);
  endtask

  task automatic drain();
    bit done = 0;
    ax_ready = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      if (m_q.size() == 0 && m_cnt == 0 && !m_v) done = 1;
      else begin
        cpl_valid = (m_cnt > 0);
        cpl_resp  = 2'b00;
        tick();
        cpl_valid = 1'b0;
      end
    end
    chk("drain_done", done, 1'b1);
    chk("drain_idle", idle, 1'b1);
  endtask

  initial begin
    int acc;
    rst = 1'b0;
    req_valid = 1'b0;
    set_req(32'h0, 8'h0, 3'h0, 1'b0);
    abort = 1'b0;
    ax_ready = 1'b1;
    cpl_valid = 1'b0;
    cpl_resp = 2'b00;
    err_clr = 1'b0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b1;
    chk("rst_valid", ax_valid, 1'b0);
    chk("rst_addr", ax_addr, 32'h0);
    chk("rst_len", ax_len, 8'h0);
    chk("rst_size", ax_size, 3'h0);
    chk("rst_burst", ax_burst, 2'b01);
    chk("rst_err", err, 2'b00);
    chk("rst_out", outstanding, 8'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_ready", req_ready, 1'b1);

    // Single INCR request: visible two cycles after acceptance.
    set_req(32'h1000, 8'd15, 3'd2, 1'b0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("lat_n1_valid", ax_valid, 1'b0);
    tick();
    chk("lat_n2_valid", ax_valid, 1'b1);
    chk("lat_addr", ax_addr, 32'h1000);
    chk("lat_len", ax_len, 8'd15);
    chk("lat_size", ax_size, 3'd2);
    chk("lat_burst", ax_burst, 2'b01);
    chk("lat_out", outstanding, 8'd1);
    tick();
    chk("lat_one_beat", ax_valid, 1'b0);
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("lat_cpl_out", outstanding, 8'd0);
    chk("lat_cpl_idle", idle, 1'b1);

    // Back-pressure: 1 held + 4 queued, then ordered release.
    log_q.delete();
    ax_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      set_req(32'h2000 + 32'(acc) * 32'h100, 8'd1, 3'd3, 1'b0);
      req_valid = 1'b1;
      if (req_ready) acc++;
      tick();
    end
    chk("bp_accepts", acc, 5);
    chk("bp_ready_low", req_ready, 1'b0);
    chk("bp_hold_valid", ax_valid, 1'b1);
    chk("bp_hold_addr", ax_addr, 32'h2000);
    ax_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      set_req(32'h2000 + 32'(acc) * 32'h100, 8'd1, 3'd3, 1'b0);
      req_valid = (acc < 6);
      if (req_valid && req_ready) acc++;
      cpl_valid = (m_cnt > 0);
      tick();
    end
    req_valid = 1'b0;
    cpl_valid = 1'b0;
    chk("bp_total", acc, 6);
    chk("bp_beats", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk("bp_order", log_q[i], 32'h2000 + 32'(i) * 32'h100);
    drain();

    // Outstanding limit of 4 with 6 requests and no completions.
    log_q.delete();
    push_n(6, 32'h3000, 12);
    repeat (4) tick();
    chk("lim_beats", log_q.size(), 4);
    chk("lim_out", outstanding, 8'd4);
    chk("lim_valid", ax_valid, 1'b0);
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("lim_cpl_out", outstanding, 8'd3);
    chk("lim_cpl_valid", ax_valid, 1'b0);
    tick();
    chk("lim_next_valid", ax_valid, 1'b1);
    chk("lim_next_addr", ax_addr, 32'h3400);
    chk("lim_next_out", outstanding, 8'd4);
    drain();

    // Abort with a held beat and three queued entries.
    ax_ready = 1'b0;
    push_n(4, 32'h4000, 10);
    tick();
    chk("ab_pre_valid", ax_valid, 1'b1);
    chk("ab_pre_addr", ax_addr, 32'h4000);
    abort = 1'b1;
    tick();
    chk("ab_ready", req_ready, 1'b0);
    chk("ab_hold_addr", ax_addr, 32'h4000);
    tick();
    chk("ab_hold_valid", ax_valid, 1'b1);
    ax_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_done_valid", ax_valid, 1'b0);
    repeat (2) tick();
    chk("ab_no_more", ax_valid, 1'b0);
    chk("ab_out", outstanding, 8'd1);
    chk("ab_not_idle", idle, 1'b0);
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("ab_idle", idle, 1'b1);

    // Error flags: response error, stray completion, clear.
    set_req(32'h5000, 8'd0, 3'd2, 1'b0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("er_out", outstanding, 8'd1);
    cpl_valid = 1'b1;
    cpl_resp = 2'b10;
    tick();
    cpl_valid = 1'b0;
    cpl_resp = 2'b00;
    chk("er_slverr", err, 2'b01);
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("er_stray", err, 2'b11);
    chk("er_stray_cnt", outstanding, 8'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("er_clr", err, 2'b00);
    err_clr = 1'b1;
    cpl_valid = 1'b1;
    tick();
    err_clr = 1'b0;
    cpl_valid = 1'b0;
    chk("er_clr_vs_new", err, 2'b10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("er_clr2", err, 2'b00);

    // FIXED burst loaded alongside a completion at count 3.
    push_n(3, 32'h6000, 8);
    repeat (3) tick();
    chk("fx_pre_out", outstanding, 8'd3);
    set_req(32'h6800, 8'd7, 3'd1, 1'b1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("fx_valid", ax_valid, 1'b1);
    chk("fx_burst", ax_burst, 2'b00);
    chk("fx_len", ax_len, 8'd7);
    chk("fx_out", outstanding, 8'd3);
    drain();

    // Reset asserted while a beat is held.
    ax_ready = 1'b0;
    set_req(32'h7000, 8'd2, 3'd2, 1'b0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mr_pre_valid", ax_valid, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_valid", ax_valid, 1'b0);
    chk("mr_out", outstanding, 8'd0);
    chk("mr_addr", ax_addr, 32'h0);
    chk("mr_burst", ax_burst, 2'b01);
    tick();
    chk("mr_idle", idle, 1'b1);

    chk_en = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
